cpu_seq_ctrl: RTL and testbench

Multicycle sequencer for the five-stage CPU. It steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, driving one enable per stage. It handles the memory wait handshake and skips stages the instruction class does not need. It sits beside the DECODER and the datapath registers and owns PC update and halt.

---
 rtl/cpu_seq_ctrl_pkg.sv | 25 ++
 rtl/cpu_seq_ctrl_if.sv | 30 +++
 rtl/cpu_seq_ctrl_perf_cnt.sv | 21 ++
 rtl/cpu_seq_ctrl.sv | 110 +++++++++++
 tb/tb_cpu_seq_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared definitions for the multicycle CPU sequencer: state encodings,
// instruction classes and the default memory wait limit.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6,
    ST_ILLEGAL = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    OPC_ALU    = 2'd0,
    OPC_LOAD   = 2'd1,
    OPC_STORE  = 2'd2,
    OPC_BRANCH = 2'd3
  } op_class_e;

  localparam int unsigned MEM_WAIT_MAX_DEF = 15;

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Sequencer control bundle. Handshake: mem_req is held while in FETCH/MEM and a
// request completes on the cycle where mem_req && mem_ready; mem_ready is ignored otherwise.
interface cpu_seq_ctrl_if;
  logic       run;
  logic       halt_req;
  logic [1:0] op_class;
  logic       mem_ready;
  logic       fetch_en;
  logic       decode_en;
  logic       exec_en;
  logic       mem_en;
  logic       wb_en;
  logic       mem_req;
  logic       pc_we;
  logic [2:0] state;
  logic       busy;
  logic       mem_err;

  modport master (
    input  run, halt_req, op_class, mem_ready,
    output fetch_en, decode_en, exec_en, mem_en, wb_en,
    output mem_req, pc_we, state, busy, mem_err
  );

  modport slave (
    output run, halt_req, op_class, mem_ready,
    input  fetch_en, decode_en, exec_en, mem_en, wb_en,
    input  mem_req, pc_we, state, busy, mem_err
  );
endinterface

// File: rtl/cpu_seq_ctrl_perf_cnt.sv
// Retired-instruction and stall-cycle counters for the sequencer; both wrap at 2^32.
module seq_perf_cnt (
  input  logic        clk,
  input  logic        clr,
  input  logic        retire_inc,
  input  logic        stall_inc,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk) begin
    if (!clr) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (retire_inc) retired_cnt <= retired_cnt + 32'd1;
      if (stall_inc)  stall_cnt   <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory wait timeout and halt.
// Define CPU_SEQ_PERF_EN to add the retired_cnt / stall_cnt performance counters.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = MEM_WAIT_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  cpu_seq_ctrl_if.master       bus
`ifdef CPU_SEQ_PERF_EN
  ,
  output logic [31:0]          retired_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  state_e     state_q, state_d;
  op_class_e  cls_q;
  logic       halt_pend_q;
  logic       mem_err_q;
  logic [3:0] wait_q;

  logic is_busy;
  logic wait_cyc;
  logic timeout;
  logic end_instr;

  assign is_busy  = state_q inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB};
  // mem_req is high exactly in FETCH/MEM, so gating on the state ignores stray mem_ready.
  assign wait_cyc = (state_q == ST_FETCH || state_q == ST_MEM) && !bus.mem_ready;
  assign timeout  = wait_cyc && (({28'd0, wait_q} + 32'd1) >= 32'(MEM_WAIT_MAX));

  always_comb begin
    state_d   = state_q;
    end_instr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.halt_req)  state_d = ST_HALT;
        else if (bus.run)  state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (timeout)            state_d = ST_HALT;
        else if (bus.mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        case (cls_q)
          OPC_ALU:    state_d = ST_WB;
          OPC_LOAD:   state_d = ST_MEM;
          OPC_STORE:  state_d = ST_MEM;
          OPC_BRANCH: end_instr = 1'b1;
        endcase
      end
      ST_MEM: begin
        if (timeout)                 state_d = ST_HALT;
        else if (bus.mem_ready) begin
          if (cls_q == OPC_LOAD)     state_d = ST_WB;
          else                       end_instr = 1'b1;
        end
      end
      ST_WB:   end_instr = 1'b1;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    // A halt request arriving on the final cycle still wins over the next fetch.
    if (end_instr) state_d = (halt_pend_q || bus.halt_req) ? ST_HALT : ST_FETCH;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      cls_q       <= OPC_ALU;
      halt_pend_q <= 1'b0;
      mem_err_q   <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE)     cls_q       <= op_class_e'(bus.op_class);
      if (is_busy && bus.halt_req)  halt_pend_q <= 1'b1;
      if (timeout)                  mem_err_q   <= 1'b1;
      if (state_d != state_q)                  wait_q <= '0;
      else if (wait_cyc && wait_q != 4'hF)     wait_q <= wait_q + 4'd1;
    end
  end

  assign bus.state     = state_q;
  assign bus.fetch_en  = (state_q == ST_FETCH);
  assign bus.decode_en = (state_q == ST_DECODE);
  assign bus.exec_en   = (state_q == ST_EXEC);
  assign bus.mem_en    = (state_q == ST_MEM);
  assign bus.wb_en     = (state_q == ST_WB);
  assign bus.mem_req   = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign bus.busy      = is_busy;
  assign bus.mem_err   = mem_err_q;
  // Masked by clr so an instruction abandoned by reset never retires.
  assign bus.pc_we     = end_instr && clr;

`ifdef CPU_SEQ_PERF_EN
  seq_perf_cnt u_perf (
    .clk         (clk),
    .clr         (clr),
    .retire_inc  (bus.pc_we),
    .stall_inc   (wait_cyc && clr),
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: class latency table plus hand-written
// wait, timeout, halt and reset sequences. Perf checks compile under CPU_SEQ_PERF_EN.
module tb_cpu_seq_ctrl;
  import cpu_pkg::*;

  logic clk;
  logic clr;
  cpu_seq_ctrl_if bus ();
`ifdef CPU_SEQ_PERF_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif

  cpu_seq_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
`ifdef CPU_SEQ_PERF_EN
    ,
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [2:0] exp_q[$];
  logic       exp_err;
  int         n_checks;
  int         n_errors;

  typedef struct {
    logic [1:0]      cls;
    int              lat;
    logic [4:0][2:0] seq;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] en_of(input logic [2:0] s);
    case (s)
      3'd1:    return 5'b10000;
      3'd2:    return 5'b01000;
      3'd3:    return 5'b00100;
      3'd4:    return 5'b00010;
      3'd5:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  // drive one cycle of inputs, check outputs against the next expected state, advance a cycle
  task automatic step(input logic r, input logic h, input logic [1:0] c, input logic rdy,
                      output logic pcw);
    logic [2:0] e;
    bus.run = r; bus.halt_req = h; bus.op_class = c; bus.mem_ready = rdy;
    #1;
    pcw = bus.pc_we;
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL exp_q_empty: got state %0d expected none", bus.state);
    end else begin
      e = exp_q.pop_front();
      chk("state", 32'(bus.state), 32'(e));
      chk("enables", 32'({bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en}),
          32'(en_of(e)));
      chk("busy", 32'(bus.busy), 32'(e >= 3'd1 && e <= 3'd5));
      chk("mem_req", 32'(bus.mem_req), 32'(e == 3'd1 || e == 3'd4));
      chk("mem_err", 32'(bus.mem_err), 32'(exp_err));
      if (bus.pc_we && bus.fetch_en) chk("pc_we_fetch_overlap", 32'd1, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  // run one instruction from FETCH; mem_ready withheld for fw/mw cycles in FETCH/MEM
  task automatic run_instr(input logic [1:0] cls, input int fw, input int mw,
                           input logic halt_exec, input int exp_lat, input string nm);
    int fc, mc, lat;
    logic rdy, h, pcw, done;
    fc = 0; mc = 0; lat = 0; done = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      rdy = 1'b1; h = 1'b0;
      if (bus.state == 3'd1 && fc < fw) begin rdy = 1'b0; fc++; end
      if (bus.state == 3'd4 && mc < mw) begin rdy = 1'b0; mc++; end
      if (bus.state == 3'd3 && halt_exec) h = 1'b1;
      step(1'b0, h, cls, rdy, pcw);
      if (pcw) begin done = 1'b1; lat = cyc + 1; end
    end
    chk({nm, "_pc_we_seen"}, 32'(done), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_seq_consumed"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_n(input logic [2:0] s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(s);
  endtask

  initial begin
    logic pcw;
    n_checks = 0; n_errors = 0; exp_err = 1'b0;
    vecs[0].cls = 2'd0; vecs[0].lat = 4; vecs[0].seq = {3'd0, 3'd5, 3'd3, 3'd2, 3'd1};
    vecs[1].cls = 2'd1; vecs[1].lat = 5; vecs[1].seq = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    vecs[2].cls = 2'd2; vecs[2].lat = 4; vecs[2].seq = {3'd0, 3'd4, 3'd3, 3'd2, 3'd1};
    vecs[3].cls = 2'd3; vecs[3].lat = 3; vecs[3].seq = {3'd0, 3'd0, 3'd3, 3'd2, 3'd1};

    clr = 1'b0;
    bus.run = 1'b0; bus.halt_req = 1'b0; bus.op_class = 2'd0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;

    // reset held for two cycles, then start
    push_n(3'd0, 2);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 2'd0, 1'b1, pcw);
      chk("reset_pc_we", 32'(pcw), 32'd0);
    end
    clr = 1'b1;
    push_n(3'd0, 1);
    step(1'b1, 1'b0, 2'd0, 1'b1, pcw);

    // class latency table, mem_ready tied high
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < vecs[v].lat; k++) exp_q.push_back(vecs[v].seq[k]);
      run_instr(vecs[v].cls, 0, 0, 1'b0, vecs[v].lat, $sformatf("class%0d", v));
    end

    // LOAD with 3 fetch waits and 2 mem waits
    exp_q.push_back(3'd1); exp_q.push_back(3'd1); exp_q.push_back(3'd1); exp_q.push_back(3'd1);
    exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    exp_q.push_back(3'd4); exp_q.push_back(3'd4); exp_q.push_back(3'd4); exp_q.push_back(3'd5);
    run_instr(2'd1, 3, 2, 1'b0, 10, "load_wait");
`ifdef CPU_SEQ_PERF_EN
    chk("stall_cnt", stall_cnt, 32'd5);
    chk("retired_cnt", retired_cnt, 32'd5);
`endif

    // halt pulsed in EXEC of a STORE: MEM completes, then HALT forever
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3); exp_q.push_back(3'd4);
    run_instr(2'd2, 0, 0, 1'b1, 4, "store_halt");
    push_n(3'd6, 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 2'd0, 1'b1, pcw);
      chk("halt_pc_we", 32'(pcw), 32'd0);
    end

    // reset out of HALT, then halt_req in IDLE goes straight to HALT
    clr = 1'b0; push_n(3'd6, 1); step(1'b0, 1'b0, 2'd0, 1'b0, pcw);
    clr = 1'b1; push_n(3'd0, 1); step(1'b0, 1'b1, 2'd0, 1'b0, pcw);
    push_n(3'd6, 1); step(1'b0, 1'b0, 2'd0, 1'b0, pcw);
    clr = 1'b0; push_n(3'd6, 1); step(1'b0, 1'b0, 2'd0, 1'b0, pcw);
    clr = 1'b1;

    // fetch timeout after 15 wait cycles
    push_n(3'd0, 1); step(1'b1, 1'b0, 2'd0, 1'b0, pcw);
    push_n(3'd1, 15);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 2'd0, 1'b0, pcw);
      chk("timeout_pc_we", 32'(pcw), 32'd0);
    end
    exp_err = 1'b1;
    push_n(3'd6, 2);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 2'd0, 1'b1, pcw);

    // reset while waiting in MEM of a LOAD
    clr = 1'b0; push_n(3'd6, 1); step(1'b0, 1'b0, 2'd0, 1'b0, pcw);
    clr = 1'b1; exp_err = 1'b0;
    push_n(3'd0, 1); step(1'b1, 1'b0, 2'd1, 1'b1, pcw);
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd1, 1'b1, pcw);
    push_n(3'd4, 1); step(1'b0, 1'b0, 2'd1, 1'b0, pcw);
    clr = 1'b0;
    push_n(3'd4, 1); step(1'b0, 1'b0, 2'd1, 1'b0, pcw);
    chk("reset_mem_pc_we", 32'(pcw), 32'd0);
    clr = 1'b1;
    push_n(3'd0, 1); step(1'b0, 1'b0, 2'd0, 1'b1, pcw);
`ifdef CPU_SEQ_PERF_EN
    chk("retired_after_reset", retired_cnt, 32'd0);
`endif

    // halt_pend cleared by reset: BRANCH returns to FETCH; then halt on BRANCH's last cycle
    push_n(3'd0, 1); step(1'b1, 1'b0, 2'd3, 1'b1, pcw);
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    run_instr(2'd3, 0, 0, 1'b0, 3, "branch_plain");
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3);
    run_instr(2'd3, 0, 0, 1'b1, 3, "branch_halt");
    push_n(3'd6, 2);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 2'd0, 1'b1, pcw);
`ifdef CPU_SEQ_PERF_EN
    chk("retired_final", retired_cnt, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
